// File: rtl/zigbee_tag_pkg.sv
// Shared types and default parameters for the ZigBee backscatter tag datapath.
package zigbee_tag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int DEF_HALF_PERIOD   = 2;
  localparam int DEF_SYMBOL_CYCLES = 320;
  localparam int DEF_SKIP_SYMBOLS  = 8;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_carrier_gen.sv
// Divide-by-(2*HALF_PERIOD) square-wave carrier with enable and synchronous clear.
module shift_carrier_gen
  import zigbee_tag_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic carrier
);

  localparam int HALF_W = cnt_width(HALF_PERIOD);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_PERIOD - 1);

  logic [HALF_W-1:0] half_cnt_reg;
  logic              carrier_reg;

  // Clear beats enable so a new packet always starts at carrier phase 0.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      half_cnt_reg <= '0;
      carrier_reg  <= 1'b0;
    end else if (enable) begin
      if (half_cnt_reg == HALF_LAST) begin
        half_cnt_reg <= '0;
        carrier_reg  <= ~carrier_reg;
      end else begin
        half_cnt_reg <= half_cnt_reg + HALF_W'(1);
      end
    end
  end

  assign carrier = carrier_reg;

endmodule

// File: rtl/zigbee_phase_modulator.sv
// Tag-side 0/pi phase modulator driving the backscatter RF switch.
// Define SWITCH_IDLE_TONE_EN to let the carrier free-run while idle.
module zigbee_phase_modulator
  import zigbee_tag_pkg::*;
#(
  parameter int HALF_PERIOD   = DEF_HALF_PERIOD,
  parameter int SYMBOL_CYCLES = DEF_SYMBOL_CYCLES,
  parameter int SKIP_SYMBOLS  = DEF_SKIP_SYMBOLS
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic bit_data,
  input  logic bit_last,
  input  logic bit_valid,
  output logic bit_ready,
  output logic switch_out,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int SYM_W  = cnt_width(SYMBOL_CYCLES);
  localparam int SKIP_W = cnt_width(SKIP_SYMBOLS);
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SYMBOL_CYCLES - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_SYMBOLS > 0) ? SKIP_SYMBOLS - 1 : 0);

  state_t            state_reg, state_next;
  logic [SYM_W-1:0]  sym_cnt_reg, sym_cnt_next;
  logic [SKIP_W-1:0] skip_cnt_reg, skip_cnt_next;
  logic              phase_reg, phase_next;
  logic              last_flag_reg, last_flag_next;
  logic              underrun_reg, underrun_next;
  logic              buf_full_reg, buf_full_next;
  logic              buf_data_reg, buf_data_next;
  logic              buf_last_reg, buf_last_next;
  logic              switch_out_reg;

  logic sym_end;
  logic start_accept;
  logic load_point;
  logic consume;
  logic load;
  logic done_int;
  logic carrier;
  logic carrier_en;
  logic carrier_clr;

  assign sym_end = (sym_cnt_reg == SYM_LAST);
  assign load    = bit_valid & ~buf_full_reg;

  always_comb begin
    state_next     = state_reg;
    sym_cnt_next   = sym_cnt_reg;
    skip_cnt_next  = skip_cnt_reg;
    phase_next     = phase_reg;
    last_flag_next = last_flag_reg;
    underrun_next  = underrun_reg;
    start_accept   = 1'b0;
    load_point     = 1'b0;
    consume        = 1'b0;
    done_int       = 1'b0;

    case (state_reg)
      IDLE: begin
        sym_cnt_next  = '0;
        skip_cnt_next = '0;
        phase_next    = 1'b0;
        if (start) begin
          start_accept   = 1'b1;
          underrun_next  = 1'b0;
          last_flag_next = 1'b0;
          if (SKIP_SYMBOLS == 0) begin
            load_point = 1'b1;
          end else begin
            state_next = SKIP;
          end
        end
      end

      SKIP: begin
        phase_next   = 1'b0;
        sym_cnt_next = sym_end ? '0 : sym_cnt_reg + SYM_W'(1);
        if (sym_end) begin
          if (skip_cnt_reg == SKIP_LAST) begin
            load_point = 1'b1;
          end else begin
            skip_cnt_next = skip_cnt_reg + SKIP_W'(1);
          end
        end
      end

      DATA: begin
        sym_cnt_next = sym_end ? '0 : sym_cnt_reg + SYM_W'(1);
        if (sym_end) begin
          if (last_flag_reg) begin
            done_int   = 1'b1;
            state_next = IDLE;
            phase_next = 1'b0;
          end else begin
            load_point = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A load point with an empty buffer aborts the packet without a done pulse.
    if (load_point) begin
      if (buf_full_reg) begin
        consume        = 1'b1;
        phase_next     = buf_data_reg;
        last_flag_next = buf_last_reg;
        state_next     = DATA;
      end else begin
        underrun_next = 1'b1;
        phase_next    = 1'b0;
        state_next    = IDLE;
        sym_cnt_next  = '0;
      end
    end
  end

  always_comb begin
    buf_full_next = load | (buf_full_reg & ~consume);
    buf_data_next = load ? bit_data : buf_data_reg;
    buf_last_next = load ? bit_last : buf_last_reg;
  end

`ifdef SWITCH_IDLE_TONE_EN
  assign carrier_en  = 1'b1;
  assign carrier_clr = start_accept;
`else
  // Clearing on the way into IDLE keeps the carrier at 0 for every idle cycle.
  assign carrier_en  = (state_reg != IDLE);
  assign carrier_clr = start_accept | (state_next == IDLE);
`endif

  shift_carrier_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_carrier (
    .clock   (clock),
    .reset   (reset),
    .enable  (carrier_en),
    .clear   (carrier_clr),
    .carrier (carrier)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      sym_cnt_reg    <= '0;
      skip_cnt_reg   <= '0;
      phase_reg      <= 1'b0;
      last_flag_reg  <= 1'b0;
      underrun_reg   <= 1'b0;
      buf_full_reg   <= 1'b0;
      buf_data_reg   <= 1'b0;
      buf_last_reg   <= 1'b0;
      switch_out_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sym_cnt_reg    <= sym_cnt_next;
      skip_cnt_reg   <= skip_cnt_next;
      phase_reg      <= phase_next;
      last_flag_reg  <= last_flag_next;
      underrun_reg   <= underrun_next;
      buf_full_reg   <= buf_full_next;
      buf_data_reg   <= buf_data_next;
      buf_last_reg   <= buf_last_next;
      switch_out_reg <= carrier ^ phase_reg;
    end
  end

  assign bit_ready  = ~buf_full_reg;
  assign switch_out = switch_out_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = done_int;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_zigbee_phase_modulator.sv
// Self-checking bench for zigbee_phase_modulator (HALF_PERIOD=2, SYMBOL_CYCLES=8, SKIP_SYMBOLS=2).
module tb_zigbee_phase_modulator;

  localparam int H  = 2;
  localparam int SC = 8;
  localparam int SK = 2;
`ifdef SWITCH_IDLE_TONE_EN
  localparam bit TONE = 1'b1;
`else
  localparam bit TONE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, start, bit_data, bit_last, bit_valid;
  logic bit_ready, switch_out, busy, done, underrun;

  int tests = 0;
  int fails = 0;

  zigbee_phase_modulator #(
    .HALF_PERIOD(H), .SYMBOL_CYCLES(SC), .SKIP_SYMBOLS(SK)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .bit_data(bit_data), .bit_last(bit_last), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .switch_out(switch_out), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         n;
    logic [7:0] bits;      // bit 0 is sent first
    bit         preload;
    int         exp_len;   // cycles from start to done, inclusive of done
    logic [15:0] mask;     // expected phase per symbol, symbol 0 at LSB
    int         mid_start; // window in which to pulse a stray start (0 = none)
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: in packet cycle j (1..len) carrier = floor((j-1)/H) mod 2, phase = mask[symbol].
  function automatic logic exp_sw(input int j, input int len, input logic [15:0] mask);
    logic c;
    c = (((j - 1) / H) % 2) == 1;
    if (j < 1) return 1'b0;
    if (j > len) return TONE ? c : 1'b0;
    return c ^ mask[(j - 1) / SC];
  endfunction

  task automatic offer(input int n, input logic [7:0] bits, input int idx);
    logic [7:0] b;
    b = bits;
    bit_valid = (idx < n);
    bit_data  = (idx < n) ? b[idx] : 1'b0;
    bit_last  = (idx == n - 1);
  endtask

  task automatic run_packet(input string name, input int n, input logic [7:0] bits,
                            input bit preload, input int exp_len, input logic [15:0] mask,
                            input int mid_start);
    int idx = 0;
    int wave_err = 0, busy_err = 0, done_cnt = 0, done_at = -1, rdy_win = 0;
    bit acc;
    offer(n, bits, idx);
    if (preload) begin
      for (int t = 0; t < 10 && idx == 0; t++) begin
        acc = bit_valid & bit_ready;
        tick();
        if (acc) idx = 1;
      end
      check({name, "_preload"}, idx, 1);
      offer(n, bits, idx);
    end
    start = 1'b1;
    acc = bit_valid & bit_ready;
    tick();
    start = 1'b0;
    if (acc) idx++;
    offer(n, bits, idx);
    for (int k = 1; k <= exp_len + 2; k++) begin
      if (!(TONE && k == 1) && switch_out !== exp_sw(k - 1, exp_len, mask)) wave_err++;
      if (done === 1'b1) begin done_cnt++; done_at = k; end
      if (busy !== (k <= exp_len)) busy_err++;
      if (k == 1) check({name, "_underrun_clr"}, underrun, 0);
      if (bit_valid && bit_ready && k <= exp_len) rdy_win++;
      start = (k == mid_start);
      acc = bit_valid & bit_ready;
      tick();
      if (acc) idx++;
      offer(n, bits, idx);
    end
    start = 1'b0;
    check({name, "_wave_errs"}, wave_err, 0);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_done_at"}, done_at, exp_len);
    check({name, "_busy_errs"}, busy_err, 0);
    check({name, "_bits_taken"}, idx, n);
    check({name, "_ready_slots"}, rdy_win, n - 1);
    check({name, "_no_underrun"}, underrun, 0);
    $display("[TB] packet %s n=%0d bits=%b len=%0d done_at=%0d wave_errs=%0d",
             name, n, bits, exp_len, done_at, wave_err);
  endtask

  initial begin
    logic sw_hist[20];
    int   err;
    int   n;
    logic [7:0] bits;
    logic [15:0] mask;

    vecs[0] = '{n: 3, bits: 8'b101,    preload: 1'b1, exp_len: 40, mask: 16'h0014, mid_start: 0};
    vecs[1] = '{n: 1, bits: 8'b0,      preload: 1'b1, exp_len: 24, mask: 16'h0000, mid_start: 0};
    vecs[2] = '{n: 6, bits: 8'b001011, preload: 1'b1, exp_len: 64, mask: 16'h002C, mid_start: 30};
    vecs[3] = '{n: 2, bits: 8'b10,     preload: 1'b0, exp_len: 32, mask: 16'h0008, mid_start: 0};

    reset = 1'b1; start = 1'b0; bit_data = 1'b0; bit_last = 1'b0; bit_valid = 1'b0;

    // Reset and idle
    for (int i = 0; i < 3; i++) tick();
    check("rst_switch_out", switch_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_bit_ready", bit_ready, 1);
    reset = 1'b0;
    err = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sw_hist[i] = switch_out;
      if (busy !== 1'b0 || done !== 1'b0 || underrun !== 1'b0 || bit_ready !== 1'b1) err++;
    end
    check("idle_ctrl_errs", err, 0);
    err = 0;
    for (int i = 0; i < 20; i++) begin
      if (TONE) begin
        if (i >= 4 && (sw_hist[i] === sw_hist[i - 2] || sw_hist[i] !== sw_hist[i - 4])) err++;
      end else if (sw_hist[i] !== 1'b0) begin
        err++;
      end
    end
    check("idle_switch_errs", err, 0);
    $display("[TB] reset/idle checked, switch errs=%0d", err);

    // Underrun: empty buffer, no bits supplied
    start = 1'b1;
    tick();
    start = 1'b0;
    err = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done === 1'b1) err++;
      if (k == 16) check("ur_busy_at_16", busy, 1);
      if (k == 17) begin
        check("ur_flag", underrun, 1);
        check("ur_busy", busy, 0);
      end
      if (k == 18 && !TONE) check("ur_switch", switch_out, 0);
      tick();
    end
    check("ur_no_done", err, 0);
    check("ur_sticky", underrun, 1);
    $display("[TB] underrun sequence checked, underrun=%0d busy=%0d", underrun, busy);

    // Table-driven packets (nominal, 1-bit, 6-bit backpressure with stray start, no preload)
    for (int v = 0; v < 4; v++) begin
      run_packet($sformatf("vec%0d", v), vecs[v].n, vecs[v].bits, vecs[v].preload,
                 vecs[v].exp_len, vecs[v].mask, vecs[v].mid_start);
    end

    // Reset mid-packet, then a nominal packet
    bit_valid = 1'b1; bit_data = 1'b1; bit_last = 1'b0;
    for (int t = 0; t < 10 && bit_ready; t++) tick();
    bit_data = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    check("mid_ready_before", bit_ready, 0);
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    bit_valid = 1'b0;
    tick();
    check("mid_rst_switch_out", switch_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_bit_ready", bit_ready, 1);
    reset = 1'b0;
    tick();
    $display("[TB] mid-packet reset checked");
    run_packet("after_rst", vecs[0].n, vecs[0].bits, 1'b1, vecs[0].exp_len, vecs[0].mask, 0);

    // Randomized packets against the arithmetic model
    for (int r = 0; r < 6; r++) begin
      n    = $urandom_range(1, 6);
      bits = 8'($urandom) & 8'((1 << n) - 1);
      mask = 16'(bits) << SK;
      for (int g = 0; g < $urandom_range(0, 5); g++) tick();
      run_packet($sformatf("rnd%0d", r), n, bits, 1'($urandom_range(0, 1)),
                 (SK + n) * SC, mask, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
